// File: rtl/iir_pkg.sv
// Shared constants and types for the IIR output-response compactor.
package iir_pkg;

  localparam int unsigned IIR_W      = 32;
  localparam int unsigned IIR_PERIOD = 31;

  localparam logic [IIR_W-1:0] IIR_POLY_DEFAULT = 32'h8020_0003;

  typedef enum logic {
    RUN,
    DONE
  } iir_sig_state_t;

endpackage

// File: rtl/misr32.sv
// Combinational single-step MISR: shift in the feedback parity, then fold in the data word.
module misr32
  import iir_pkg::*;
(
  input  logic [IIR_W-1:0] sig,
  input  logic [IIR_W-1:0] data,
  input  logic [IIR_W-1:0] poly,
  output logic [IIR_W-1:0] sig_next
);

  logic fb;

  always_comb begin
    fb       = ^(sig & poly);
    sig_next = {sig[IIR_W-2:0], fb} ^ data;
  end

endmodule

// File: rtl/iir_sig.sv
// MISR signature compactor with golden compare. Optional debug taps under IIR_SIG_DEBUG_EN
// expose the live signature and vector count.
module iir_sig
  import iir_pkg::*;
#(
  parameter int unsigned       NUM_VECTORS  = 64,
  parameter logic [IIR_W-1:0]  SEED         = 32'h0000_0000,
  parameter logic [IIR_W-1:0]  POLY         = IIR_POLY_DEFAULT,
  parameter logic [IIR_W-1:0]  GOLDEN_SIG   = 32'h0000_0000,
  parameter int unsigned       SAMPLE_CYCLE = IIR_PERIOD - 1,
  localparam int unsigned      VEC_W        = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IIR_W-1:0] outData,
  output logic             done,
  output logic             pass
`ifdef IIR_SIG_DEBUG_EN
  ,
  output logic [IIR_W-1:0] sig_out,
  output logic [VEC_W-1:0] vec_out
`endif
);

  if (NUM_VECTORS < 1) begin : g_bad_num_vectors
    $error("iir_sig: NUM_VECTORS must be at least 1");
  end
  if (SAMPLE_CYCLE > 31) begin : g_bad_sample_cycle
    $error("iir_sig: SAMPLE_CYCLE must fit the 5-bit period counter");
  end

  localparam logic [4:0]       SampleCnt = 5'(SAMPLE_CYCLE);
  localparam logic [VEC_W-1:0] LastVec   = VEC_W'(NUM_VECTORS - 1);

  iir_sig_state_t   state_q;
  logic [4:0]       cnt_q;
  logic [IIR_W-1:0] sig_q;
  logic [IIR_W-1:0] sig_next;
  logic [VEC_W-1:0] vec_q;
  logic             sample;
  logic             last;

  misr32 u_misr (
    .sig     (sig_q),
    .data    (outData),
    .poly    (POLY),
    .sig_next(sig_next)
  );

  always_comb begin
    sample = (state_q == RUN) && (cnt_q == SampleCnt);
    last   = sample && (vec_q == LastVec);
  end

  // DONE is absorbing: nothing below updates once the final compare has been taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sig_q   <= SEED;
      vec_q   <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_q <= (cnt_q == SampleCnt) ? 5'd0 : cnt_q + 5'd1;
      if (sample) begin
        sig_q <= sig_next;
        vec_q <= vec_q + VEC_W'(1);
      end
      if (last) begin
        state_q <= DONE;
        done    <= 1'b1;
        pass    <= (sig_next == GOLDEN_SIG);
      end
    end
  end

`ifdef IIR_SIG_DEBUG_EN
  always_comb begin
    sig_out = sig_q;
    vec_out = vec_q;
  end
`endif

endmodule

// File: tb/tb_iir_sig.sv
// Directed bench for iir_sig: several parameterisations share one clock, reset and data stream.
module tb_iir_sig;
  import iir_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] out_data = '0;

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic done_g0, pass_g0, done_g1, pass_g1, done_g2, pass_g2;
  logic done_v2, pass_v2, done_v4, pass_v4;

`ifdef IIR_SIG_DEBUG_EN
  logic [31:0] sig_g0, sig_g1, sig_g2, sig_v2, sig_v4;
  logic [0:0]  vec_g0, vec_g1, vec_g2;
  logic [1:0]  vec_v2;
  logic [2:0]  vec_v4;
`endif

  iir_sig #(.NUM_VECTORS(1), .GOLDEN_SIG(32'h0)) u_g0 (
    .clk(clk), .rst(rst), .outData(out_data), .done(done_g0), .pass(pass_g0)
`ifdef IIR_SIG_DEBUG_EN
    , .sig_out(sig_g0), .vec_out(vec_g0)
`endif
  );

  iir_sig #(.NUM_VECTORS(1), .GOLDEN_SIG(32'h1)) u_g1 (
    .clk(clk), .rst(rst), .outData(out_data), .done(done_g1), .pass(pass_g1)
`ifdef IIR_SIG_DEBUG_EN
    , .sig_out(sig_g1), .vec_out(vec_g1)
`endif
  );

  iir_sig #(.NUM_VECTORS(1), .GOLDEN_SIG(32'h2)) u_g2 (
    .clk(clk), .rst(rst), .outData(out_data), .done(done_g2), .pass(pass_g2)
`ifdef IIR_SIG_DEBUG_EN
    , .sig_out(sig_g2), .vec_out(vec_g2)
`endif
  );

  iir_sig #(.NUM_VECTORS(2), .GOLDEN_SIG(32'h2)) u_v2 (
    .clk(clk), .rst(rst), .outData(out_data), .done(done_v2), .pass(pass_v2)
`ifdef IIR_SIG_DEBUG_EN
    , .sig_out(sig_v2), .vec_out(vec_v2)
`endif
  );

  // With data 1 every sample: 0 -> 1 -> 2 -> 4 -> 9.
  iir_sig #(.NUM_VECTORS(4), .GOLDEN_SIG(32'h9)) u_v4 (
    .clk(clk), .rst(rst), .outData(out_data), .done(done_v4), .pass(pass_v4)
`ifdef IIR_SIG_DEBUG_EN
    , .sig_out(sig_v4), .vec_out(vec_v4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Release lands on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset(input logic [31:0] data);
    @(negedge clk);
    rst      = 1'b0;
    out_data = data;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

`ifdef IIR_SIG_DEBUG_EN
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
    logic fb;
    fb = ^(s & 32'h8020_0003);
    return {s[30:0], fb} ^ d;
  endfunction
`endif

  logic [31:0] win_val;

  initial begin
    // Reset state, checked while rst is low.
    @(negedge clk);
    #1;
    check_eq("reset_done", {31'd0, done_v4}, 32'd0);
    check_eq("reset_pass", {31'd0, pass_v4}, 32'd0);

    // Null data: one vector of zeros against a zero golden.
    do_reset(32'h0);
    for (int e = 1; e <= 30; e++) begin
      step();
      check_eq($sformatf("null_done_e%0d", e), {31'd0, done_g0}, 32'd0);
    end
    step();
    check_eq("null_done_e31", {31'd0, done_g0}, 32'd1);
    check_eq("null_pass_e31", {31'd0, pass_g0}, 32'd1);
    check_eq("null_g1_fail", {31'd0, pass_g1}, 32'd0);
    for (int e = 0; e < 100; e++) begin
      out_data = 32'(e * 32'h0101_0101);
      step();
      check_eq("null_hold", {30'd0, done_g0, pass_g0}, 32'd3);
    end

    // Constant data 1: single, two and four vector runs.
    do_reset(32'h1);
    begin
`ifdef IIR_SIG_DEBUG_EN
      logic [31:0] model = 32'h0;
`endif
      for (int e = 1; e <= 124; e++) begin
        step();
        if (e == 30) check_eq("v2_done_e30", {31'd0, done_v2}, 32'd0);
        if (e == 31) begin
          check_eq("one_g1_pass", {30'd0, done_g1, pass_g1}, 32'd3);
          check_eq("one_g2_fail", {30'd0, done_g2, pass_g2}, 32'd2);
          check_eq("one_g0_fail", {30'd0, done_g0, pass_g0}, 32'd2);
          check_eq("v2_done_e31", {31'd0, done_v2}, 32'd0);
        end
        if (e == 61) check_eq("v2_done_e61", {31'd0, done_v2}, 32'd0);
        if (e == 62) check_eq("v2_pass_e62", {30'd0, done_v2, pass_v2}, 32'd3);
        if (e == 123) check_eq("v4_done_e123", {31'd0, done_v4}, 32'd0);
        if (e == 124) check_eq("v4_pass_e124", {30'd0, done_v4, pass_v4}, 32'd3);
`ifdef IIR_SIG_DEBUG_EN
        if (e == 30) check_eq("dbg_vec_e30", {30'd0, vec_v2}, 32'd0);
        if (e == 31) check_eq("dbg_vec_e31", {30'd0, vec_v2}, 32'd1);
        if (e == 62) check_eq("dbg_vec_e62", {30'd0, vec_v2}, 32'd2);
        if (e % 31 == 0) begin
          model = model_step(model, 32'h1);
          check_eq($sformatf("dbg_sig_e%0d", e), sig_v4, model);
        end
`endif
      end
    end

    // Sampling window: only the value at edge 31 may reach the signature.
    do_reset(32'hFFFF_FFFF);
    for (int e = 1; e <= 40; e++) begin
      if (e == 31)         win_val = 32'h1;
      else if (e % 2 == 1) win_val = 32'hFFFF_FFFF;
      else                 win_val = 32'h0;
      out_data = win_val;
      step();
    end
    check_eq("win_g1_pass", {30'd0, done_g1, pass_g1}, 32'd3);
    check_eq("win_g2_fail", {30'd0, done_g2, pass_g2}, 32'd2);

    // Mid-run reset after edge 70, then a clean four-vector run.
    do_reset(32'h1);
    for (int e = 1; e <= 70; e++) step();
    check_eq("mid_v2_done_pre", {31'd0, done_v2}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_v2_clear", {30'd0, done_v2, pass_v2}, 32'd0);
    check_eq("mid_g1_clear", {30'd0, done_g1, pass_g1}, 32'd0);
`ifdef IIR_SIG_DEBUG_EN
    check_eq("mid_sig_clear", sig_v4, 32'h0);
    check_eq("mid_vec_clear", {29'd0, vec_v4}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 124; e++) begin
      step();
      if (e == 123) check_eq("rst_v4_done_e123", {31'd0, done_v4}, 32'd0);
      if (e == 124) check_eq("rst_v4_pass_e124", {30'd0, done_v4, pass_v4}, 32'd3);
    end
`ifdef IIR_SIG_DEBUG_EN
    check_eq("rst_v4_sig", sig_v4, 32'h9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iir_sig.md
# iir_sig

Output-response compactor that sits directly downstream of the IIR filter in the on-chip test flow. It samples the filter's 32-bit output once per stimulus period, folds each sample into a 32-bit MISR signature, and after a fixed number of vectors compares the signature against a golden value and reports pass/fail. Its internal period counter runs in lock-step with the stimulus generator: both leave reset together and use the same 31-cycle period.

## Interface
- `NUM_VECTORS`, default 64: number of samples compacted before the compare.
- `SEED`, default 32'h0000_0000: MISR reset value.
- `POLY`, default 32'h8020_0003: feedback tap mask.
- `GOLDEN_SIG`, default 32'h0000_0000: expected final signature.
- `SAMPLE_CYCLE`, default 30: period-counter value at which `outData` is sampled.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `outData`, input, 32: filter response.
- `done`, output, 1: compare complete. Sticky until reset.
- `pass`, output, 1: final signature equals `GOLDEN_SIG`. Meaningful only when `done` is high.

## Operation
- States: RUN and DONE.
  - Asynchronous reset puts the block in RUN with the period counter at 0, signature at `SEED`, vector count at 0, `done` at 0 and `pass` at 0.
- Period counter: 5 bits. It increments every cycle in RUN and wraps from `SAMPLE_CYCLE` to 0, giving a period of `SAMPLE_CYCLE`+1 = 31 cycles.
- Sample event: RUN and counter == `SAMPLE_CYCLE`. On that edge:
  - fb = XOR-reduce(sig & `POLY`).
  - sig <= {sig[30:0], fb} ^ `outData`.
  - Vector count increments.
- Last sample: a sample event where vector count == `NUM_VECTORS`-1. On that same edge:
  - The state moves to DONE.
  - `done` <= 1.
  - `pass` <= (next sig == `GOLDEN_SIG`).
- DONE is absorbing:
  - Counter, signature, `done` and `pass` all hold.
  - `outData` is ignored.
  - Only `rst` leaves DONE.
- Vector count width is $clog2(`NUM_VECTORS`+1). `NUM_VECTORS` must be ≥ 1; an elaboration-time check enforces this.
- All arithmetic is unsigned. The MISR is a pure XOR/shift; there are no carries.

## Timing
- The first sample is taken on the 31st rising edge after `rst` deasserts. Sample k (1-based) is taken on edge 31k.
- `done` rises on edge 31·`NUM_VECTORS`. It is registered, with no combinational path from `outData`.
- `pass` becomes valid on the same edge that `done` rises.
- Asserting `rst` mid-run clears every output and all state immediately, without waiting for a clock edge. Counting restarts after deassertion.
- `outData` must be stable at the sample edge. This is guaranteed by the upstream filter, which settles within its period.

## Configuration
- `IIR_SIG_DEBUG_EN` defined: two extra outputs are added.
  - `sig_out` [31:0]: the live signature register.
  - `vec_out`: the live vector count, at the vector-count width.
  - Both are 0/`SEED` in reset and track the internal registers cycle-for-cycle.
- `IIR_SIG_DEBUG_EN` undefined: these ports and their logic are absent.
- Compacting and compare behaviour is identical with and without the macro.

## Structure
- Shared package `iir_pkg` holds:
  - `IIR_W` = 32.
  - `IIR_PERIOD` = 31.
  - The state enum `iir_sig_state_t` {RUN, DONE}.
  - The default `POLY` constant.
- Sub-module `misr32` is purely combinational: inputs sig, data and poly, output next sig. The top level instantiates it once and holds the signature register, the counters and the FSM.

## Test plan
- Null data: `NUM_VECTORS`=1, `SEED`=0, `outData`=0, `GOLDEN_SIG`=0.
  - Expect `done`=0 through edge 30.
  - Expect `done`=1 and `pass`=1 at edge 31, held for 100 more cycles.
- Single vector: `NUM_VECTORS`=1, `outData`=32'h1, `GOLDEN_SIG`=32'h1 → `pass`=1.
  - Rerun with `GOLDEN_SIG`=32'h2 → `pass`=0, `done`=1.
- Two vectors: `NUM_VECTORS`=2, `outData`=32'h1 at both samples.
  - Expected sig: 32'h1 after edge 31, then 32'h2 ^ fb(1) ^ 1 = 32'h2 after edge 62.
  - `GOLDEN_SIG`=32'h2 → `pass`=1.
- Sampling window: with `NUM_VECTORS`=1, toggle `outData` every cycle except edge 31.
  - The signature must reflect only the value present at edge 31.
- Mid-run reset: `NUM_VECTORS`=4, assert `rst` at edge 70 between clock edges.
  - Outputs clear immediately.
  - After release, `done` rises exactly 124 edges later with the same signature as a clean run.
- Debug build: `IIR_SIG_DEBUG_EN` defined.
  - `vec_out` steps 0→1→2 at edges 31 and 62.
  - `sig_out` matches a reference-model MISR at every sample.
